mux_n_1_hs: RTL and testbench
=============================

Name: mux_n_1_hs

Overview:
- Parametrised N:1 registered multiplexer with valid/ready handshake on every input channel and on the output.
- Generalises the 2:1 registered mux to configurable data width and channel count.
- Adds a 1-deep output buffer with backpressure and a selectable arbitration mode: fixed select or round-robin.
- Sits between multiple producer channels and a single downstream consumer in lab datapaths.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- NUM_CH, 4, number of input channels (>=2).
- SEL_W, $clog2(NUM_CH), width of the sel and out_ch fields; derived, not overridden.
- MODE, 0, arbitration mode: 0 = fixed (sel input chooses the channel), 1 = round-robin among valid channels (sel ignored).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- sel  input  SEL_W  channel select; used only when MODE=0.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset: clk and reset are as already decided (one clock, reset asynchronous and active-high). While reset is asserted: out_valid=0, out_data=0, out_ch=0, round-robin pointer last=NUM_CH-1 (so channel 0 has highest priority first). in_ready is all 0 while reset is high.
- Transfer rule: a transfer occurs on any port in a cycle where valid and ready are both 1 at the rising edge.
- Output buffer: two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid || out_ready. The buffer can accept a word when it is empty or is being drained in the same cycle.
- Grant g (combinational):
  - MODE=0: g=sel when sel<NUM_CH. If sel>=NUM_CH (non-power-of-2 NUM_CH), there is no grant.
  - MODE=1: g is the first i with in_valid[i]=1, scanning last+1, last+2, ... modulo NUM_CH. There is no grant if in_valid is all 0.
- in_ready[i] = load_en && grant_exists && (i==g). At most one bit of in_ready is set. in_ready must not depend on in_valid[g] in MODE=0. In MODE=1 it depends on in_valid only through g.
- Load: on a transfer from channel g, out_data<=in_data[g], out_ch<=g, out_valid<=1. Latency is 1 cycle from input acceptance to out_valid.
- Drain without load: out_valid<=0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge, out_valid stays 1. Full throughput is 1 word/cycle.
- Backpressure: while out_valid=1 && out_ready=0, out_data and out_ch are stable and all in_ready=0.
- Round-robin pointer: last<=g only on an accepted input transfer. It is unchanged on stall or idle. It wraps from NUM_CH-1 to 0.
- Changing sel mid-stall is legal. It affects only the next accepted word, never the held word.
- Reset mid-operation: a held word is discarded and there is no output transfer. The pointer returns to NUM_CH-1.
- No combinational path from in_valid/in_data to out_*. A path from out_ready to in_ready is allowed.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=0, MODE_RR=1 localparams.
  - A typedef for the output buffer state enum {EMPTY, FULL}.
- Sub-module rr_arbiter (parameter NUM_CH):
  - Inputs: req[NUM_CH], last[SEL_W].
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate-priority encoder.
  - Instantiated only under a MODE=1 generate branch.

Test Plan:
- Reset: assert reset mid-cycle (async) with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately, before the next edge; in_ready=0000 while reset is high.
- MODE=0, WIDTH=8, NUM_CH=4, sel=2, in_valid=0100, in_data ch2=0xA5, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
- Backpressure: hold out_ready=0 for 3 cycles after a load of 0x3C; toggle sel=0..3 -> out_data stays 0x3C, in_ready=0000 throughout; raise out_ready -> word drains, next selected word loads the same edge.
- Throughput: out_ready=1, ch1 valid every cycle with data 0x01,0x02,...,0x08 -> out_data equals the input sequence delayed by 1 cycle, with no bubbles.
- MODE=1 round-robin: in_valid=1111 continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1; with in_valid=1010 -> 1,3,1,3.
- MODE=1 pointer hold: grant ch2, then stall 4 cycles with in_valid=1111 -> after release the next grant is ch3, not ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 handshake multiplexer.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: grants the first requester after 'last', wrapping.
// Purely combinational, no state, no backpressure of its own.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk last+1, last+2, ... with explicit wrap so non-power-of-2 counts never index past the top channel.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_cand    = last;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = (w_cand == SEL_W'(NUM_CH - 1)) ? '0 : w_cand + 1'b1;
            if (!gnt_valid && req[w_cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_hs.sv
// N:1 registered mux, 1-cycle latency into a 1-deep output buffer; fixed-select or round-robin grant.
// in_ready drops for every channel while the held word is stalled (out_valid && !out_ready).
module mux_n_1_hs
    import mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int MODE   = MODE_FIXED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    buf_state_e         r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_ch;

    logic               w_load_en;
    logic               w_gnt_vld;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic [NUM_CH-1:0]  w_rdy;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_ch_dat [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_ch_dat[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign w_load_en = !out_valid || out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] r_last;
        logic             w_unused_sel;

        rr_arbiter #(
            .NUM_CH (NUM_CH),
            .SEL_W  (SEL_W)
        ) u_arb (
            .req       (in_valid),
            .last      (r_last),
            .gnt_valid (w_gnt_vld),
            .gnt_idx   (w_gnt_idx)
        );

        // Pointer advances only on an accepted word, so a stalled grant keeps its turn.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_last <= SEL_W'(NUM_CH - 1);
            end else if (w_xfer) begin
                r_last <= w_gnt_idx;
            end
        end

        assign w_unused_sel = ^sel;
    end else begin : g_fixed
        assign w_gnt_vld = (int'(sel) < NUM_CH);
        assign w_gnt_idx = sel;
    end

    always_comb begin
        w_rdy = '0;
        if (!reset && w_load_en && w_gnt_vld) begin
            w_rdy[w_gnt_idx] = 1'b1;
        end
    end

    assign in_ready = w_rdy;
    assign w_xfer   = |(w_rdy & in_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_ch    <= '0;
        end else if (w_xfer) begin
            r_state <= FULL;
            r_data  <= w_ch_dat[w_gnt_idx];
            r_ch    <= w_gnt_idx;
        end else if (out_ready) begin
            r_state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_n_1_hs.sv
// Scoreboard bench for a fixed-select and a round-robin instance of mux_n_1_hs (WIDTH=8, NUM_CH=4).
module tb_mux_n_1_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data_f, in_data_r;
    logic [3:0]  in_valid_f, in_valid_r;
    logic [3:0]  in_ready_f, in_ready_r;
    logic [1:0]  sel_f, sel_r;
    logic [7:0]  out_data_f, out_data_r;
    logic [1:0]  out_ch_f, out_ch_r;
    logic        out_valid_f, out_valid_r;
    logic        out_ready_f, out_ready_r;

    int checks = 0;
    int errors = 0;
    logic [9:0] q_f[$];
    logic [9:0] q_r[$];
    int last_r = 3;

    mux_n_1_hs #(.WIDTH(8), .NUM_CH(4), .MODE(0)) u_fix (
        .clk(clk), .reset(reset), .in_data(in_data_f), .in_valid(in_valid_f),
        .in_ready(in_ready_f), .sel(sel_f), .out_data(out_data_f), .out_ch(out_ch_f),
        .out_valid(out_valid_f), .out_ready(out_ready_f)
    );

    mux_n_1_hs #(.WIDTH(8), .NUM_CH(4), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(in_data_r), .in_valid(in_valid_r),
        .in_ready(in_ready_r), .sel(sel_r), .out_data(out_data_r), .out_ch(out_ch_r),
        .out_valid(out_valid_r), .out_ready(out_ready_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: buffer is full iff a word is queued; grant is sel, or first valid after last (mod 4).
    task automatic model_step(input int d, input logic [3:0] vld, input logic [31:0] dat,
                              input logic [1:0] s, input logic ordy);
        int sz;
        int g;
        int idx;
        logic gv;
        logic [3:0] exp_rdy;
        logic [3:0] act_rdy;
        logic act_ov;
        string p;
        p       = (d == 0) ? "fx" : "rr";
        sz      = (d == 0) ? q_f.size() : q_r.size();
        act_rdy = (d == 0) ? in_ready_f : in_ready_r;
        act_ov  = (d == 0) ? out_valid_f : out_valid_r;
        chk({p, "_out_valid"}, 32'(act_ov), 32'(sz != 0));
        gv = 1'b0;
        g  = 0;
        if (d == 0) begin
            gv = 1'b1;
            g  = int'(s);
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = (last_r + k) % 4;
                if (!gv && vld[idx]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end
        exp_rdy = 4'b0000;
        if ((sz == 0 || ordy) && gv) exp_rdy[g] = 1'b1;
        chk({p, "_in_ready"}, 32'(act_rdy), 32'(exp_rdy));
        if (exp_rdy[g] && vld[g]) begin
            if (d == 0) q_f.push_back({2'(g), dat[g*8 +: 8]});
            else begin
                q_r.push_back({2'(g), dat[g*8 +: 8]});
                last_r = g;
            end
        end
    endtask

    task automatic drive_cycle(input logic [3:0] vf, input logic [31:0] df, input logic [1:0] sf,
                               input logic rf, input logic [3:0] vr, input logic [31:0] dr,
                               input logic rr);
        @(negedge clk);
        in_valid_f  = vf;  in_data_f = df;  sel_f = sf;  out_ready_f = rf;
        in_valid_r  = vr;  in_data_r = dr;  sel_r = 2'($urandom);  out_ready_r = rr;
        #1;
        model_step(0, vf, df, sf, rf);
        model_step(1, vr, dr, 2'd0, rr);
    endtask

    task automatic fx(input logic [3:0] v, input logic [31:0] d, input logic [1:0] s, input logic r);
        drive_cycle(v, d, s, r, 4'b0000, 32'h0, 1'b1);
    endtask

    task automatic rrc(input logic [3:0] v, input logic r);
        drive_cycle(4'b0000, 32'h0, 2'd0, 1'b1, v, $urandom, r);
    endtask

    task automatic pop_chk(input int d);
        logic [9:0] e;
        string p;
        p = (d == 0) ? "fx" : "rr";
        if ((d == 0 && q_f.size() == 0) || (d == 1 && q_r.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_output: got a word, expected none", p);
        end else begin
            e = (d == 0) ? q_f.pop_front() : q_r.pop_front();
            chk({p, "_out_data"}, 32'((d == 0) ? out_data_f : out_data_r), 32'(e[7:0]));
            chk({p, "_out_ch"},   32'((d == 0) ? out_ch_f : out_ch_r),     32'(e[9:8]));
        end
    endtask

    // Monitor: consumes a word whenever the output handshake completes at the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (out_valid_f && out_ready_f) pop_chk(0);
                if (out_valid_r && out_ready_r) pop_chk(1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid_f = '0; in_data_f = '0; sel_f = '0; out_ready_f = 1'b1;
        in_valid_r = '0; in_data_r = '0; sel_r = '0; out_ready_r = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_fx_out_valid", 32'(out_valid_f), 32'd0);
        chk("rst_fx_out_data",  32'(out_data_f),  32'd0);
        chk("rst_fx_in_ready",  32'(in_ready_f),  32'd0);
        chk("rst_rr_out_valid", 32'(out_valid_r), 32'd0);
        chk("rst_rr_in_ready",  32'(in_ready_r),  32'd0);
        reset = 1'b0;

        // Fixed select: single word, backpressure with sel sweep, then streaming ch1.
        fx(4'b0100, 32'h00A5_0000, 2'd2, 1'b1);
        fx(4'b0000, 32'h0, 2'd0, 1'b1);
        fx(4'b0001, 32'h0000_003C, 2'd0, 1'b1);
        for (int k = 0; k < 3; k++) fx(4'b1111, $urandom, 2'(k), 1'b0);
        fx(4'b1111, $urandom, 2'd3, 1'b1);
        for (int k = 1; k <= 8; k++) fx(4'b0010, 32'(k) << 8, 2'd1, 1'b1);
        fx(4'b0000, 32'h0, 2'd0, 1'b1);
        fx(4'b0000, 32'h0, 2'd0, 1'b1);

        // Round-robin: all valid, alternating pair, then pointer hold across a stall.
        for (int k = 0; k < 6; k++) rrc(4'b1111, 1'b1);
        for (int k = 0; k < 4; k++) rrc(4'b1010, 1'b1);
        rrc(4'b0100, 1'b1);
        for (int k = 0; k < 4; k++) rrc(4'b1111, 1'b0);
        rrc(4'b1111, 1'b1);
        rrc(4'b0000, 1'b1);
        rrc(4'b0000, 1'b1);

        for (int n = 0; n < 600; n++) begin
            drive_cycle(4'($urandom), $urandom, 2'($urandom), ($urandom_range(0, 9) < 7),
                        4'($urandom), $urandom, ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset while both buffers hold a stalled word.
        drive_cycle(4'b1111, $urandom, 2'd1, 1'b0, 4'b1111, $urandom, 1'b0);
        drive_cycle(4'b1111, $urandom, 2'd2, 1'b0, 4'b1111, $urandom, 1'b0);
        #2;
        chk("pre_rst_fx_out_valid", 32'(out_valid_f), 32'd1);
        chk("pre_rst_rr_out_valid", 32'(out_valid_r), 32'd1);
        reset = 1'b1;
        in_valid_f = '0;
        in_valid_r = '0;
        #1;
        chk("arst_fx_out_valid", 32'(out_valid_f), 32'd0);
        chk("arst_fx_out_data",  32'(out_data_f),  32'd0);
        chk("arst_fx_out_ch",    32'(out_ch_f),    32'd0);
        chk("arst_rr_out_valid", 32'(out_valid_r), 32'd0);
        chk("arst_rr_out_data",  32'(out_data_r),  32'd0);
        chk("arst_rr_out_ch",    32'(out_ch_r),    32'd0);
        chk("arst_fx_in_ready",  32'(in_ready_f),  32'd0);
        chk("arst_rr_in_ready",  32'(in_ready_r),  32'd0);
        q_f.delete();
        q_r.delete();
        last_r = 3;
        @(negedge clk);
        #1;
        chk("rst_hold_fx_in_ready", 32'(in_ready_f), 32'd0);
        chk("rst_hold_rr_in_ready", 32'(in_ready_r), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) rrc(4'b1111, 1'b1);
        for (int n = 0; n < 200; n++) begin
            drive_cycle(4'($urandom), $urandom, 2'($urandom), ($urandom_range(0, 9) < 6),
                        4'($urandom), $urandom, ($urandom_range(0, 9) < 6));
        end
        drive_cycle(4'b0000, 32'h0, 2'd0, 1'b1, 4'b0000, 32'h0, 1'b1);
        drive_cycle(4'b0000, 32'h0, 2'd0, 1'b1, 4'b0000, 32'h0, 1'b1);
        #3;
        chk("fx_scoreboard_drained", 32'(q_f.size()), 32'd0);
        chk("rr_scoreboard_drained", 32'(q_r.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
